// File: rtl/riscat_pipe_pkg.sv
// Shared types for the operand-fetch pipeline slice.
package riscat_pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PAYLOAD_W = 64;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef struct packed {
    xlen_t                rs1_val;
    xlen_t                rs2_val;
    reg_addr_t            rd;
    logic                 rd_we;
    logic [PAYLOAD_W-1:0] payload;
  } of_out_t;

  function automatic logic [31:0] reg_onehot(input reg_addr_t a);
    return 32'b1 << a;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
// set_* marks a new in-flight writer, clr_* retires one, q*_addr query pending bits.
module regfile_scoreboard
  import riscat_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t q0_addr,
  input  reg_addr_t q1_addr,
  input  reg_addr_t q2_addr,
  output logic      q0_pend,
  output logic      q1_pend,
  output logic      q2_pend
);

  logic [31:0] pend;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_addr != REG_ZERO) set_vec = reg_onehot(set_addr);
    if (clr_en && clr_addr != REG_ZERO) clr_vec = reg_onehot(clr_addr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      pend <= '0;
    end else begin
      // set applied after clear so a same-register collision stays pending
      pend <= ((pend & ~clr_vec) | set_vec) & ~32'b1;
    end
  end

  assign q0_pend = pend[q0_addr];
  assign q1_pend = pend[q1_addr];
  assign q2_pend = pend[q2_addr];

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-read stage: RF read, writeback forwarding, RAW/WAW stall, output register.
// in_* from decode, rf_* to/from register file, wb_* writeback, out_* to execute.
module operand_fetch_stage
  import riscat_pipe_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic [4:0]           in_rd,
  input  logic                 in_rd_we,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 rf_rd0_en,
  output logic                 rf_rd1_en,
  output logic [4:0]           rf_rd0_addr,
  output logic [4:0]           rf_rd1_addr,
  input  logic [XLEN-1:0]      rf_rd0_data,
  input  logic [XLEN-1:0]      rf_rd1_data,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [4:0]           out_rd,
  output logic                 out_rd_we,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic    need_rs1, need_rs2, need_rd;
  logic    wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic    pend_rs1, pend_rs2, pend_rd;
  logic    raw_1, raw_2, waw, stall;
  logic    accept;
  xlen_t   op1, op2;
  of_out_t out_q;

  assign need_rs1 = in_use_rs1 && (in_rs1 != REG_ZERO);
  assign need_rs2 = in_use_rs2 && (in_rs2 != REG_ZERO);
  assign need_rd  = in_rd_we   && (in_rd  != REG_ZERO);

  assign wb_hit_rs1 = wb_valid && (wb_addr == in_rs1);
  assign wb_hit_rs2 = wb_valid && (wb_addr == in_rs2);
  assign wb_hit_rd  = wb_valid && (wb_addr == in_rd);

  assign rf_rd0_en   = in_valid && need_rs1;
  assign rf_rd1_en   = in_valid && need_rs2;
  assign rf_rd0_addr = in_rs1;
  assign rf_rd1_addr = in_rs2;

  regfile_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .set_en   (accept && in_rd_we),
    .set_addr (in_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q0_addr  (in_rs1),
    .q1_addr  (in_rs2),
    .q2_addr  (in_rd),
    .q0_pend  (pend_rs1),
    .q1_pend  (pend_rs2),
    .q2_pend  (pend_rd)
  );

  // a writeback retiring this cycle resolves the hazard it would otherwise cause
  assign raw_1 = need_rs1 && pend_rs1 && !wb_hit_rs1;
  assign raw_2 = need_rs2 && pend_rs2 && !wb_hit_rs2;
  assign waw   = need_rd  && pend_rd  && !wb_hit_rd;
  assign stall = raw_1 || raw_2 || waw;

  assign in_ready = reset_n && !flush && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (need_rs1) op1 = wb_hit_rs1 ? wb_data : rf_rd0_data;
    if (need_rs2) op2 = wb_hit_rs2 ? wb_data : rf_rd1_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_q.rs1_val <= op1;
      out_q.rs2_val <= op2;
      out_q.rd      <= in_rd;
      out_q.rd_we   <= in_rd_we;
      out_q.payload <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1_val = out_q.rs1_val;
  assign out_rs2_val = out_q.rs2_val;
  assign out_rd      = out_q.rd;
  assign out_rd_we   = out_q.rd_we;
  assign out_payload = out_q.payload;

endmodule
